// File: rtl/serial_rca_ctrl.sv
// rtl/serial_rca_ctrl.sv - bit-serial adder controller sharing one mux-carry full-adder cell, LSB first.
// Optional subtract mode is enabled by defining SERIAL_RCA_SUB_EN.
module serial_rca_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
`ifdef SERIAL_RCA_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_d;
   logic [WIDTH-1:0] a_sh, a_sh_d, b_sh, b_sh_d, res_sh, res_sh_d;
   logic [WIDTH-1:0] sum_d, res_next, b_cap;
   logic             carry, carry_d, c_out_d, busy_d, done_d;
   logic             bit_sum, carry_nx, c_cap;
   logic [CW-1:0]    cnt, cnt_d;

   // Shared full-adder cell: carry-out as a 2:1 mux selected by the A bit.
   assign bit_sum  = a_sh[0] ^ b_sh[0] ^ carry;
   assign carry_nx = a_sh[0] ? (b_sh[0] | carry) : (b_sh[0] & carry);

   generate
      if (WIDTH == 1) begin : g_res_w1
         assign res_next = bit_sum;
      end else begin : g_res_wn
         assign res_next = {bit_sum, res_sh[WIDTH-1:1]};
      end
   endgenerate

`ifdef SERIAL_RCA_SUB_EN
   // Subtract as a + ~b + 1; c_in is ignored when sub is set.
   assign b_cap = sub ? ~b : b;
   assign c_cap = sub | c_in;
`else
   assign b_cap = b;
   assign c_cap = c_in;
`endif

   always_comb begin
      state_d  = state;
      a_sh_d   = a_sh;
      b_sh_d   = b_sh;
      res_sh_d = res_sh;
      carry_d  = carry;
      cnt_d    = cnt;
      sum_d    = sum;
      c_out_d  = c_out;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      case (state)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b_cap;
               carry_d = c_cap;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            res_sh_d = res_next;
            carry_d  = carry_nx;
            a_sh_d   = a_sh >> 1;
            b_sh_d   = b_sh >> 1;
            cnt_d    = cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
               sum_d   = res_next;
               c_out_d = carry_nx;
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               busy_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum    <= '0;
         c_out  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_d;
         a_sh   <= a_sh_d;
         b_sh   <= b_sh_d;
         res_sh <= res_sh_d;
         carry  <= carry_d;
         cnt    <= cnt_d;
         sum    <= sum_d;
         c_out  <= c_out_d;
         busy   <= busy_d;
         done   <= done_d;
      end
   end

endmodule

// File: tb/tb_serial_rca_ctrl.sv
// tb/tb_serial_rca_ctrl.sv - self-checking bench for serial_rca_ctrl at WIDTH=4.
module tb_serial_rca_ctrl;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n, start, c_in;
   logic [W-1:0] a, b;
   logic         busy, done, c_out;
   logic [W-1:0] sum;
`ifdef SERIAL_RCA_SUB_EN
   logic         sub;
`endif

   typedef struct {
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic         vc;
      logic [W-1:0] es;
      logic         ec;
   } vec_t;

   vec_t         vecs[7];
   logic [W:0]   sb_q[$];
   int           checks = 0;
   int           errors = 0;
   int           done_count = 0;
   int           cyc = 0;

   serial_rca_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .c_in  (c_in),
`ifdef SERIAL_RCA_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .c_out (c_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Scoreboard: every done pulse pops the oldest expected {c_out, sum}.
   always @(negedge clk) begin
      logic [W:0] exp;
      chk("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
      if (done === 1'b1) begin
         done_count++;
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 required=0");
         end else begin
            exp = sb_q.pop_front();
            chk("sum", {28'd0, sum}, {28'd0, exp[W-1:0]});
            chk("c_out", {31'd0, c_out}, {31'd0, exp[W]});
         end
      end
   end

   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (done !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=0 required=1");
      end
   endtask

   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input logic [W-1:0] es, input logic ec, input string nm);
      int n, nb;
      @(negedge clk);
      a = ta; b = tb_v; c_in = tc; start = 1'b1;
      sb_q.push_back({ec, es});
      @(negedge clk);
      start = 1'b0;
      n = 0; nb = 0;
      while (done !== 1'b1 && n < 40) begin
         if (busy === 1'b1) nb++;
         @(negedge clk);
         n++;
      end
      chk({nm, "_latency"}, n, W);
      chk({nm, "_busy_cycles"}, nb, W);
      @(negedge clk);
      chk({nm, "_done_one_cycle"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      int n, t1, t2, dc0;
      logic [W:0] full;
      logic [W-1:0] ra, rb;
      logic rc;

      vecs[0] = '{4'b0011, 4'b0101, 1'b0, 4'b1000, 1'b0};
      vecs[1] = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1};
      vecs[2] = '{4'b0111, 4'b1000, 1'b1, 4'b0000, 1'b1};
      vecs[3] = '{4'd0,    4'd0,    1'b0, 4'd0,    1'b0};
      vecs[4] = '{4'd15,   4'd15,   1'b1, 4'd15,   1'b1};
      vecs[5] = '{4'd10,   4'd5,    1'b0, 4'd15,   1'b0};
      vecs[6] = '{4'd9,    4'd9,    1'b1, 4'd3,    1'b1};

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
`ifdef SERIAL_RCA_SUB_EN
      sub = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("reset_busy",  {31'd0, busy},  32'd0);
      chk("reset_done",  {31'd0, done},  32'd0);
      chk("reset_sum",   {28'd0, sum},   32'd0);
      chk("reset_c_out", {31'd0, c_out}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_sum_hold", {28'd0, sum}, 32'd0);

      for (int i = 0; i < 7; i++)
         do_op(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].es, vecs[i].ec, $sformatf("vec%0d", i));

      for (int i = 0; i < 6; i++) begin
         ra = W'($urandom_range(0, 15));
         rb = W'($urandom_range(0, 15));
         rc = 1'($urandom_range(0, 1));
         full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
         do_op(ra, rb, rc, full[W-1:0], full[W], $sformatf("rnd%0d", i));
      end

      // Held start with operand changes during RUN.
      @(negedge clk);
      dc0 = done_count;
      a = 4'd3; b = 4'd3; c_in = 1'b0; start = 1'b1;
      sb_q.push_back({1'b0, 4'd6});
      @(negedge clk);
      @(negedge clk);
      a = 4'd9; c_in = 1'b1;
      @(negedge clk);
      b = 4'd7;
      @(negedge clk);
      start = 1'b0;
      wait_done(n);
      repeat (4) @(negedge clk);
      #1;
      chk("held_start_one_done", done_count - dc0, 1);

      // Back-to-back: restart in the DONE cycle.
      @(negedge clk);
      a = 4'd3; b = 4'd5; c_in = 1'b0; start = 1'b1;
      sb_q.push_back({1'b0, 4'd8});
      @(negedge clk);
      start = 1'b0;
      wait_done(n);
      t1 = cyc;
      a = 4'd5; b = 4'd6; c_in = 1'b0; start = 1'b1;
      sb_q.push_back({1'b0, 4'd11});
      @(negedge clk);
      start = 1'b0;
      chk("b2b_busy_after_restart", {31'd0, busy}, 32'd1);
      wait_done(n);
      t2 = cyc;
      chk("b2b_done_spacing", t2 - t1, W + 1);
      @(negedge clk);

      // Reset during RUN: abort with no done and cleared outputs.
      a = 4'd15; b = 4'd15; c_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_busy",  {31'd0, busy},  32'd0);
      chk("abort_done",  {31'd0, done},  32'd0);
      chk("abort_sum",   {28'd0, sum},   32'd0);
      chk("abort_c_out", {31'd0, c_out}, 32'd0);
      #1;
      dc0 = done_count;
      repeat (10) @(negedge clk);
      #1;
      chk("abort_no_done", done_count - dc0, 0);

`ifdef SERIAL_RCA_SUB_EN
      sub = 1'b1;
      do_op(4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b1, "sub_pos");
      do_op(4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b0, "sub_neg");
      sub = 1'b0;
      do_op(4'b0011, 4'b0101, 1'b0, 4'b1000, 1'b0, "sub_off_add");
`endif

      repeat (2) @(negedge clk);
      chk("scoreboard_empty", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_rca_ctrl.md
Name: serial_rca_ctrl

Overview:
- Bit-serial adder controller: time-shares one full-adder cell (mux-based carry-out cell plus XOR sum) across all WIDTH operand bits, one bit per clock, LSB first.
- Sits beside the mux ripple-carry adder as the area-minimal alternative.
- Sequences operand capture, bit stepping and carry recirculation, and presents results through a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising clk edge
- start  input  1  request; accepted only in IDLE or DONE
- a  input  WIDTH  operand A, captured on the accepting edge
- b  input  WIDTH  operand B, captured on the accepting edge
- c_in  input  1  carry-in, captured on the accepting edge
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when results become valid
- sum  output  WIDTH  registered result
- c_out  output  1  registered final carry-out

Behaviour:
- Reset (rst_n low at an edge):
  - state=IDLE; busy=0, done=0, sum=0, c_out=0.
  - Internal shift registers, carry flop and bit counter cleared.
  - Reset asserted mid-RUN aborts the operation; no done pulse; partial result discarded.
- Counter width: max(1, $clog2(WIDTH)).
- Shared cell: bit_sum = a0^b0^carry; carry_next = a0 ? (b0|carry) : (b0&carry), the mux form, with a0 as select.
- IDLE:
  - start=1 at an edge: a_sh<=a, b_sh<=b, carry<=c_in, cnt<=0, state<=RUN, busy<=1.
  - start=0: hold all outputs.
- RUN, each edge:
  - res_sh <= {bit_sum, res_sh[WIDTH-1:1]}; carry <= carry_next; a_sh and b_sh shift right by 1; cnt <= cnt+1.
  - start is ignored; a, b and c_in changes have no effect.
  - On the edge where cnt==WIDTH-1: sum <= final shifted result including this bit, c_out <= carry_next, busy<=0, done<=1, state<=DONE.
- DONE, one cycle only:
  - done=1; sum and c_out valid.
  - Next edge: done<=0.
  - If start=1 on that edge, capture as in IDLE and go to RUN (back-to-back, no idle gap). Otherwise go to IDLE.
- Latency: start accepted at edge E0; done is high in the cycle following edge E0+WIDTH. Throughput is one result per WIDTH+1 cycles back-to-back.
- sum and c_out change only on the completion edge or on reset. They hold their value through IDLE and the next RUN.
- busy and done are never high together; both are registered outputs.
- WIDTH=1: RUN lasts exactly one edge; behaviour is otherwise identical.

Optional Feature:
- Macro SERIAL_RCA_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), captured with the operands.
  - sub=1 computes a - b: b is inverted on capture and carry is forced to 1, ignoring c_in.
  - c_out=1 means no borrow.
  - sub=0 behaves as plain add.
- Undefined: the sub port is absent; add only; no subtract logic synthesised.

Test Plan:
- WIDTH=4, a=4'b0011, b=4'b0101, c_in=0, start pulse -> busy high 4 cycles; done pulse in the cycle after edge E0+4; sum=4'b1000, c_out=0.
- WIDTH=4, a=4'b1111, b=4'b0001, c_in=0 -> sum=4'b0000, c_out=1. Then a=4'b0111, b=4'b1000, c_in=1 -> sum=4'b0000, c_out=1.
- Start held high plus changing a/b during RUN (a=3, b=3, then a=9 at cycle 2) -> result reflects captured operands only: sum=6, c_out=0; exactly one done pulse.
- Back-to-back: start high in the DONE cycle with a=5, b=6, c_in=0 -> next op starts immediately; second done exactly 5 cycles after the first; sum=11, c_out=0.
- rst_n low for one edge at RUN cycle 2 of a=15, b=15 -> next cycle: busy=0, done=0, sum=0, c_out=0, state IDLE; no done pulse follows.
- SERIAL_RCA_SUB_EN defined, WIDTH=4:
  - a=4'b0101, b=4'b0011, sub=1 -> sum=4'b0010, c_out=1.
  - a=4'b0011, b=4'b0101 -> sum=4'b1110, c_out=0.
